dot10_mac_scheduler: RTL and testbench
======================================

# dot10_mac_scheduler

Time-multiplexed controller that shares a single 4x4 unsigned multiplier and a 16-bit accumulator between two requesters, each submitting a 10-element dot product of 4-bit vectors. Replaces a fully parallel 10-multiplier dot-product datapath where area matters. Provides per-requester request/acknowledge, round-robin arbitration, a busy flag and a tagged result strobe. All logic runs on the rising edge of one clock; no dual-edge arithmetic.

## Interface
Parameters: none. Vector length is fixed at 10, element width at 4 bits, result width at 16 bits.

- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A request; held high until ack_a
- xa  in  40  A operand X, element k at bits [4k+3:4k], k=0..9
- ya  in  40  A operand Y, same packing
- req_b  in  1  requester B request
- xb  in  40  B operand X
- yb  in  40  B operand Y
- ack_a  out  1  one-cycle pulse: A operands captured
- ack_b  out  1  one-cycle pulse: B operands captured
- busy  out  1  high while the MAC engine is sequencing
- done  out  1  one-cycle pulse: p holds a new result
- done_id  out  1  owner of current p: 0=A, 1=B
- p  out  16  dot-product result, held until next done

## Operation
- FSM states: IDLE, RUN. Reset state IDLE.
- IDLE: at a rising edge with req_a or req_b sampled high, grant one requester:
  - only one requesting: grant it.
  - both requesting: grant the one not granted last. last_gnt resets to B, so A wins the first tie.
  - on grant: capture that requester's X/Y into internal 40-bit registers, clear acc and idx to 0, latch owner, update last_gnt, go to RUN, assert ack for the following cycle.
- RUN: each edge computes acc <= acc + zext16(x[idx]*y[idx]) and increments idx. On the edge where idx=9:
  - p <= acc + product9; done_id <= owner; done pulses; return to IDLE.
  - acc and idx freeze in IDLE.
- Arithmetic: unsigned. Product is 8 bits, zero-extended to 16. Max result 10*225 = 2250, so overflow is impossible.
- Operands are sampled only at the grant edge. Later changes on xa/ya/xb/yb do not affect the in-flight computation.
- A requester that keeps req high after its ack makes a new request. It is eligible at the next IDLE arbitration and is subject to round-robin.
- A non-granted requester's req is ignored while busy. It must stay high to be considered at the next IDLE.
- No request in IDLE: no state change, and all outputs hold except the pulses, which stay 0.

## Timing
- Reset values, forced immediately on rst_n low:
  - ack_a=0, ack_b=0, busy=0, done=0, done_id=0, p=0.
  - state=IDLE, last_gnt=B, acc=0, idx=0.
- Reset during RUN aborts the operation. No done is produced, and the captured operands are discarded.
- Let the grant edge be E0:
  - ack_x is high during cycle E0..E1.
  - busy is high from E0 to E10.
  - MAC steps occur on edges E1..E10.
  - done and the new p/done_id appear after E10.
- Latency is 10 cycles from grant to result.
- The earliest next grant is edge E10+1, so sustained throughput is one result per 11 cycles.
- ack and done are exactly one cycle wide.
- done_id and p change only on done edges.
- busy is registered and equals (state==RUN).

## Test plan
- Reset: drive rst_n=0 mid-cycle with random inputs -> all outputs 0 immediately; after release with no req, outputs stay 0.
- Single A: xa elements all 1, ya element k = k, req_a at E0 -> ack_a after E0; busy for 10 cycles; done after E10 with p=45, done_id=0.
- Max value: xb=yb=all 4'hF, req_b only -> p=2250 (16'h08CA), done_id=1.
- Simultaneous requests from reset:
  - inputs: xa=all 2, ya=all 3, xb=all 1, yb=all 15, both req high.
  - expect: A granted first, done p=60 id=0.
  - then B granted at E11, done after E21 with p=150 id=1.
- Fairness: req_a and req_b held high continuously for 4 results -> done_id sequence 0,1,0,1; every ack is a single pulse.
- Abort: assert rst_n=0 after E5 of an A operation, release two cycles later, then issue B with xb=all 3, yb=all 3 -> no done from A; B completes with p=90, done_id=1.

Source files
------------

// File: rtl/dot10_mac_scheduler.sv
// dot10_mac_scheduler
// Two requesters share one 4x4 unsigned multiplier and a 16-bit accumulator.
// Each request is a 10-element dot product of 4-bit vectors. Requests are
// arbitrated round-robin in IDLE. A granted job then takes 10 MAC cycles in RUN.
module dot10_mac_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [39:0] xa,
  input  logic [39:0] ya,
  input  logic        req_b,
  input  logic [39:0] xb,
  input  logic [39:0] yb,
  output logic        ack_a,
  output logic        ack_b,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [15:0] p
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;   // 0 = A granted last, 1 = B granted last
  logic        owner_q, owner_d;         // requester of the job in flight
  logic [39:0] x_q, x_d;
  logic [39:0] y_q, y_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  idx_q, idx_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        done_q, done_d;
  logic        done_id_q, done_id_d;
  logic [15:0] p_q, p_d;

  logic        gnt_a, gnt_b;
  logic        last_step;
  logic [39:0] x_sh, y_sh;
  logic [7:0]  prod;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    gnt_a = (state_q == IDLE) && req_a && (!req_b || last_gnt_q);
    gnt_b = (state_q == IDLE) && req_b && !gnt_a;
  end

  // Element select and product for the current MAC step.
  always_comb begin
    x_sh      = x_q >> {idx_q, 2'b00};
    y_sh      = y_q >> {idx_q, 2'b00};
    prod      = {4'b0000, x_sh[3:0]} * {4'b0000, y_sh[3:0]};
    last_step = (state_q == RUN) && (idx_q == 4'd9);
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE: if (gnt_a || gnt_b) state_d = RUN;
      RUN:  if (last_step)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values: capture on grant, accumulate in RUN.
  always_comb begin
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    ack_a_d    = gnt_a;
    ack_b_d    = gnt_b;
    done_d     = last_step;
    done_id_d  = done_id_q;
    p_d        = p_q;
    if (gnt_a || gnt_b) begin
      x_d        = gnt_b ? xb : xa;
      y_d        = gnt_b ? yb : ya;
      acc_d      = 16'd0;
      idx_d      = 4'd0;
      owner_d    = gnt_b;
      last_gnt_d = gnt_b;
    end else if (state_q == RUN) begin
      acc_d = acc_q + {8'd0, prod};
      idx_d = idx_q + 4'd1;
      if (last_step) begin
        p_d       = acc_q + {8'd0, prod};
        done_id_d = owner_q;
      end
    end
  end

  // State and datapath registers. Operand registers are reset too, so an aborted job leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      x_q        <= 40'd0;
      y_q        <= 40'd0;
      acc_q      <= 16'd0;
      idx_q      <= 4'd0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      p_q        <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      p_q        <= p_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign p       = p_q;

endmodule

// File: tb/tb_dot10_mac_scheduler.sv
// Testbench for dot10_mac_scheduler: a job-level reference model checked
// every cycle, plus directed scenarios with hand-computed results.
module tb_dot10_mac_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [39:0] xa = '0, ya = '0, xb = '0, yb = '0;
  logic        ack_a, ack_b, busy, done, done_id;
  logic [15:0] p;

  int n_checks = 0;
  int n_fail   = 0;

  dot10_mac_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .xa(xa), .ya(ya),
    .req_b(req_b), .xb(xb), .yb(yb),
    .ack_a(ack_a), .ack_b(ack_b), .busy(busy),
    .done(done), .done_id(done_id), .p(p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference dot product straight from the packing rule.
  function automatic logic [15:0] dot10(input logic [39:0] x, input logic [39:0] y);
    int s = 0;
    for (int k = 0; k < 10; k++) s += int'(x[4*k +: 4]) * int'(y[4*k +: 4]);
    return 16'(s);
  endfunction

  // Job-level model: a job occupies the engine for 10 edges after its grant.
  int          m_left;
  logic        m_last, m_owner;
  logic [15:0] m_result;
  logic        e_ack_a, e_ack_b, e_done, e_done_id;
  logic [15:0] e_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_last <= 1'b1; m_owner <= 1'b0; m_result <= '0;
      e_ack_a <= 1'b0; e_ack_b <= 1'b0; e_done <= 1'b0; e_done_id <= 1'b0; e_p <= '0;
    end else begin
      e_ack_a <= 1'b0;
      e_ack_b <= 1'b0;
      e_done  <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          e_done    <= 1'b1;
          e_p       <= m_result;
          e_done_id <= m_owner;
        end
      end else if (req_a && (!req_b || m_last)) begin
        m_left <= 10; m_owner <= 1'b0; m_last <= 1'b0; m_result <= dot10(xa, ya); e_ack_a <= 1'b1;
      end else if (req_b) begin
        m_left <= 10; m_owner <= 1'b1; m_last <= 1'b1; m_result <= dot10(xb, yb); e_ack_b <= 1'b1;
      end
    end
  end

  // Cycle compare against the model, sampled away from the active edge.
  always @(negedge clk) begin
    check("cyc_ack_a",   32'(ack_a),   32'(e_ack_a));
    check("cyc_ack_b",   32'(ack_b),   32'(e_ack_b));
    check("cyc_busy",    32'(busy),    32'(m_left > 0));
    check("cyc_done",    32'(done),    32'(e_done));
    check("cyc_done_id", 32'(done_id), 32'(e_done_id));
    check("cyc_p",       32'(p),       32'(e_p));
  end

  // Waits (bounded) for done; reports negedges elapsed and the result seen.
  task automatic wait_done(input string name, output int cyc, output logic id, output logic [15:0] res);
    cyc = 0; id = 1'b0; res = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i; id = done_id; res = p;
        return;
      end
    end
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  int          cyc;
  logic        id;
  logic [15:0] res;
  logic [3:0]  ids;

  initial begin
    // Reset: random inputs, outputs zero, and stay zero with no request.
    xa = {$urandom, $urandom}; ya = {$urandom, $urandom};
    xb = {$urandom, $urandom}; yb = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check("rst_outputs", {26'd0, ack_a, ack_b, busy, done, done_id, 1'b0} | 32'(p), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_p",    32'(p),    32'd0);

    // Single A: x all 1, y[k]=k -> 45.
    xa = 40'h11_1111_1111; ya = 40'h98_7654_3210; req_a = 1'b1;
    @(negedge clk);
    check("a_ack", 32'(ack_a), 32'd1);
    check("a_busy", 32'(busy), 32'd1);
    req_a = 1'b0; xa = '0; ya = '0;   // later operand changes must not matter
    wait_done("a", cyc, id, res);
    check("a_latency", 32'(cyc), 32'd10);
    check("a_p",  32'(res), 32'd45);
    check("a_id", 32'(id),  32'd0);

    // Max value through B.
    xb = 40'hFF_FFFF_FFFF; yb = 40'hFF_FFFF_FFFF; req_b = 1'b1;
    @(negedge clk);
    check("max_ack_b", 32'(ack_b), 32'd1);
    req_b = 1'b0;
    wait_done("max", cyc, id, res);
    check("max_p",  32'(res), 32'h08CA);
    check("max_id", 32'(id),  32'd1);

    // Simultaneous requests straight from reset: A first, then B at E11.
    pulse_reset();
    xa = 40'h22_2222_2222; ya = 40'h33_3333_3333;
    xb = 40'h11_1111_1111; yb = 40'hFF_FFFF_FFFF;
    req_a = 1'b1; req_b = 1'b1;
    @(negedge clk);
    check("tie_ack_a", 32'(ack_a), 32'd1);
    check("tie_ack_b", 32'(ack_b), 32'd0);
    req_a = 1'b0;
    wait_done("tie_a", cyc, id, res);
    check("tie_a_p",  32'(res), 32'd60);
    check("tie_a_id", 32'(id),  32'd0);
    @(negedge clk);
    check("tie_b_ack", 32'(ack_b), 32'd1);
    req_b = 1'b0;
    wait_done("tie_b", cyc, id, res);
    check("tie_b_latency", 32'(cyc), 32'd10);
    check("tie_b_p",  32'(res), 32'd150);
    check("tie_b_id", 32'(id),  32'd1);

    // Fairness: both held high for four results -> 0,1,0,1.
    req_a = 1'b1; req_b = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_done("fair", cyc, id, res);
      ids[n] = id;
      if (n == 3) begin req_a = 1'b0; req_b = 1'b0; end
    end
    check("fair_ids", 32'(ids), 32'b1010);

    // Abort: reset after E5 of an A job, then a clean B job.
    xa = 40'h55_5555_5555; ya = 40'h55_5555_5555; req_a = 1'b1;
    @(negedge clk);
    check("abort_ack_a", 32'(ack_a), 32'd1);
    req_a = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 check("abort_outputs", {26'd0, ack_a, ack_b, busy, done, done_id, 1'b0} | 32'(p), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xb = 40'h33_3333_3333; yb = 40'h33_3333_3333; req_b = 1'b1;
    @(negedge clk);
    check("abort_b_ack", 32'(ack_b), 32'd1);
    req_b = 1'b0;
    wait_done("abort_b", cyc, id, res);
    check("abort_b_latency", 32'(cyc), 32'd10);
    check("abort_b_p",  32'(res), 32'd90);
    check("abort_b_id", 32'(id),  32'd1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
